// File: rtl/stroke_generator.sv
// Synthetic rowing-stroke source: start_drive/start_recovery pulses with programmable drive length and ratio.
// Optional recovery jitter from a 16-bit LFSR when STROKE_JITTER_EN is defined; default build has none.
module stroke_generator #(
  parameter int WIDTH = 32,
  parameter int JIT_W = 4
) (
  input  logic             count_clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] drive_len,
  input  logic [WIDTH-1:0] ratio,
  output logic             start_drive,
  output logic             start_recovery,
  output logic             in_drive,
  output logic [WIDTH-1:0] stroke_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, RECOVERY} state_t;

  state_t             state;
  logic [WIDTH-1:0]   d_sh;
  logic [WIDTH-1:0]   r_sh;
  logic [WIDTH-1:0]   r_act;
  logic [WIDTH-1:0]   cnt;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   d_load;
  logic [WIDTH-1:0]   r_load;
  logic [WIDTH:0]     r_sum;
  logic [WIDTH-1:0]   r_next;
  logic [JIT_W-1:0]   jitter;
  logic               drive_entry;

  always_comb begin
    product = {{WIDTH{1'b0}}, drive_len} * {{WIDTH{1'b0}}, ratio};
    d_load  = (drive_len == '0) ? WIDTH'(1) : drive_len;
    if (|product[2*WIDTH-1:WIDTH])
      r_load = '1;
    else if (product[WIDTH-1:0] == '0)
      r_load = WIDTH'(1);
    else
      r_load = product[WIDTH-1:0];
    // Recovery length for the stroke about to start, saturating on jitter overflow.
    r_sum  = {1'b0, r_sh} + (WIDTH+1)'(jitter);
    r_next = r_sum[WIDTH] ? '1 : r_sum[WIDTH-1:0];
    drive_entry = enable && ((state == IDLE) || (state == RECOVERY && cnt == '0));
  end

`ifdef STROKE_JITTER_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign jitter  = lfsr[JIT_W-1:0];

  always_ff @(posedge count_clock or negedge reset_n) begin
    if (!reset_n)
      lfsr <= 16'hACE1;
    else if (drive_entry)
      lfsr <= {lfsr_fb, lfsr[15:1]};
  end
`else
  assign jitter = '0;
`endif

  // The drive length is consumed directly into cnt at DRIVE entry, so only the recovery length is latched.
  always_ff @(posedge count_clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      start_drive    <= 1'b0;
      start_recovery <= 1'b0;
      in_drive       <= 1'b0;
      stroke_count   <= '0;
      cnt            <= '0;
      r_act          <= '0;
      d_sh           <= WIDTH'(1);
      r_sh           <= WIDTH'(1);
    end else begin
      if (load) begin
        d_sh <= d_load;
        r_sh <= r_load;
      end
      start_drive    <= 1'b0;
      start_recovery <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        in_drive <= 1'b0;
        cnt      <= '0;
      end else begin
        case (state)
          IDLE: begin
            state       <= DRIVE;
            start_drive <= 1'b1;
            in_drive    <= 1'b1;
            cnt         <= d_sh - WIDTH'(1);
            r_act       <= r_next;
          end
          DRIVE: begin
            if (cnt == '0) begin
              state          <= RECOVERY;
              start_recovery <= 1'b1;
              in_drive       <= 1'b0;
              cnt            <= r_act - WIDTH'(1);
            end else begin
              cnt <= cnt - WIDTH'(1);
            end
          end
          RECOVERY: begin
            if (cnt == '0) begin
              state        <= DRIVE;
              stroke_count <= stroke_count + WIDTH'(1);
              start_drive  <= 1'b1;
              in_drive     <= 1'b1;
              cnt          <= d_sh - WIDTH'(1);
              r_act        <= r_next;
            end else begin
              cnt <= cnt - WIDTH'(1);
            end
          end
          default: begin
            state    <= IDLE;
            in_drive <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stroke_generator.sv
// Self-checking bench for stroke_generator (default build, jitter off).
// Reference model tracks position within the stroke period rather than a down-counter.
module tb_stroke_generator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [31:0] drive_len = '0;
  logic [31:0] ratio = '0;
  logic        sd, sr, ind;
  logic [31:0] sc;

  int n_checks = 0;
  int n_fail = 0;

  bit          m_run;
  longint      m_pos, m_d, m_r, m_dsh, m_rsh;
  logic [31:0] m_count;

  always #5 clk = ~clk;

  stroke_generator #(.WIDTH(32), .JIT_W(4)) dut (
    .count_clock   (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .load          (load),
    .drive_len     (drive_len),
    .ratio         (ratio),
    .start_drive   (sd),
    .start_recovery(sr),
    .in_drive      (ind),
    .stroke_count  (sc)
  );

  task automatic m_reset();
    m_run = 0; m_pos = 0; m_d = 1; m_r = 1;
    m_dsh = 1; m_rsh = 1; m_count = '0;
  endtask

  function automatic logic [34:0] m_exp();
    logic e_sd, e_sr, e_in;
    e_sd = m_run && (m_pos == 0);
    e_sr = m_run && (m_pos == m_d);
    e_in = m_run && (m_pos < m_d);
    return {e_sd, e_sr, e_in, m_count};
  endfunction

  // Advance model and DUT by one clock edge using the inputs currently applied.
  task automatic step();
    longint unsigned p;
    if (!enable) m_run = 0;
    else if (!m_run) begin
      m_run = 1; m_pos = 0; m_d = m_dsh; m_r = m_rsh;
    end else begin
      m_pos++;
      if (m_pos == m_d + m_r) begin
        m_pos = 0; m_count++; m_d = m_dsh; m_r = m_rsh;
      end
    end
    if (load) begin
      m_dsh = (drive_len == 0) ? 1 : longint'(drive_len);
      p = 64'(drive_len) * 64'(ratio);
      m_rsh = (p > 64'hFFFF_FFFF) ? longint'(64'hFFFF_FFFF) : ((p == 0) ? 1 : longint'(p));
    end
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    m_reset();
    #1;
    n_checks++;
    if ({sd, sr, ind, sc} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b/%b/%b cnt=%0d, want all 0", sd, sr, ind, sc);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    step();
    n_checks++;
    if ({sd, sr, ind, sc} !== m_exp()) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want %h", {sd, sr, ind, sc}, m_exp());
    end
  endtask

  task automatic test_basic();
    int sd_t, sr_t, sd2_t;
    sd_t = -1; sr_t = -1; sd2_t = -1;
    drive_len = 32'd4; ratio = 32'd2; load = 1'b1;
    step();
    enable = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (sd && sd_t < 0) sd_t = c;
      else if (sd && sd2_t < 0) sd2_t = c;
      if (sr && sr_t < 0) sr_t = c;
      n_checks++;
      if ({sd, sr, ind, sc} !== m_exp()) begin
        n_fail++;
        $display("FAIL basic cyc %0d: got %h want %h", c, {sd, sr, ind, sc}, m_exp());
      end
    end
    n_checks++;
    if (sd_t != 1 || sr_t != 5 || sd2_t != 13) begin
      n_fail++;
      $display("FAIL basic_timing: start_drive %0d, start_recovery %0d, next start_drive %0d; want 1,5,13", sd_t, sr_t, sd2_t);
    end
    $display("basic stroke: D=4 R=8 checked 30 cycles");
  endtask

  task automatic test_minimum();
    enable = 1'b0; drive_len = 32'd0; ratio = 32'd0; load = 1'b1;
    step();
    enable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      n_checks++;
      if ({sd, sr, ind, sc} !== m_exp() || (sd && sr) || (sd == sr)) begin
        n_fail++;
        $display("FAIL minimum cyc %0d: got %h want %h", c, {sd, sr, ind, sc}, m_exp());
      end
    end
    $display("minimum lengths: D=1 R=1 checked 12 cycles");
  endtask

  task automatic test_saturation();
    enable = 1'b0; drive_len = 32'h0001_0000; ratio = 32'h0001_0000; load = 1'b1;
    step();
    n_checks++;
    if (dut.r_sh !== 32'hFFFF_FFFF || m_rsh != 64'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL saturation_rsh: got %h want ffffffff", dut.r_sh);
    end
    drive_len = 32'd3; ratio = 32'd0; load = 1'b1;
    step();
    n_checks++;
    if (dut.r_sh !== 32'd1 || dut.d_sh !== 32'd3) begin
      n_fail++;
      $display("FAIL zero_product: got d_sh=%0d r_sh=%0d want 3,1", dut.d_sh, dut.r_sh);
    end
    $display("saturation: shadow registers checked");
  endtask

  task automatic test_midstroke_load();
    int guard;
    enable = 1'b0; drive_len = 32'd4; ratio = 32'd2; load = 1'b1;
    step();
    enable = 1'b1;
    guard = 0;
    do begin step(); guard++; end while (!(m_run && m_pos == m_d + 1) && guard < 50);
    n_checks++;
    if (guard >= 50) begin
      n_fail++;
      $display("FAIL midstroke_wait: recovery not reached in %0d cycles", guard);
    end
    drive_len = 32'd2; ratio = 32'd3; load = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      n_checks++;
      if ({sd, sr, ind, sc} !== m_exp()) begin
        n_fail++;
        $display("FAIL midstroke cyc %0d: got %h want %h", c, {sd, sr, ind, sc}, m_exp());
      end
    end
    $display("mid-stroke load: D=4 R=8 then D=2 R=6 checked");
  endtask

  task automatic test_abort();
    int guard;
    @(posedge clk); #1;
    enable = 1'b0;
    pulse_reset();
    drive_len = 32'd2; ratio = 32'd1; load = 1'b1;
    step();
    enable = 1'b1;
    guard = 0;
    do begin step(); guard++; end while (!(m_count == 3 && m_pos == 1) && guard < 100);
    n_checks++;
    if (guard >= 100 || sc !== 32'd3 || ind !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_setup: got count=%0d in_drive=%b want 3,1", sc, ind);
    end
    enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if ({sd, sr, ind, sc} !== {3'b000, 32'd3} || {sd, sr, ind, sc} !== m_exp()) begin
        n_fail++;
        $display("FAIL abort cyc %0d: got %h want %h", c, {sd, sr, ind, sc}, {3'b000, 32'd3});
      end
    end
    $display("abort: count held at 3");
  endtask

  task automatic test_async_reset();
    int guard;
    drive_len = 32'd3; ratio = 32'd3; load = 1'b1;
    step();
    enable = 1'b1;
    guard = 0;
    do begin step(); guard++; end while (!(m_run && m_pos == m_d + 2) && guard < 50);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({sd, sr, ind, sc} !== 35'd0 || guard >= 50) begin
      n_fail++;
      $display("FAIL async_reset: got %h want 0", {sd, sr, ind, sc});
    end
    m_reset();
    enable = 1'b0;
    #1;
    reset_n = 1'b1;
    step();
    enable = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      n_checks++;
      if ({sd, sr, ind, sc} !== m_exp() || (c == 0 && sd !== 1'b1)) begin
        n_fail++;
        $display("FAIL post_reset cyc %0d: got %h want %h", c, {sd, sr, ind, sc}, m_exp());
      end
    end
    $display("async reset: defaults D=1 R=1 checked");
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 9) == 0) begin
        load = 1'b1;
        drive_len = 32'($urandom_range(0, 6));
        ratio = 32'($urandom_range(0, 4));
      end
      step();
      n_checks++;
      if ({sd, sr, ind, sc} !== m_exp() || (sd && sr)) begin
        n_fail++; errs++;
        $display("FAIL random cyc %0d: got %h want %h", c, {sd, sr, ind, sc}, m_exp());
      end
    end
    $display("random: 600 cycles, %0d errors, strokes=%0d", errs, sc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_minimum();
    test_saturation();
    test_midstroke_load();
    test_abort();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
